// File: rtl/jt6295_pkg.sv
// Shared widths, legality checks and the saturating clamp for the jt6295 mixer family.
package jt6295_pkg;

  typedef struct packed {
    logic signed [31:0] val;
    logic               clip;
  } sat_t;

  // Slot counter must be able to hold CH itself (the saturated value).
  function automatic int slot_w(input int ch);
    return (ch < 2) ? 1 : $clog2(ch + 1);
  endfunction

  function automatic int acc_w(input int ch, input int iw);
    return iw + $clog2(ch) + 1;
  endfunction

  function automatic bit cfg_ok(input int ch, input int iw, input int ow);
    return (ch >= 1) && (ch <= 16) && (ow >= iw) && (ow <= 24);
  endfunction

  function automatic sat_t saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t               r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    r.clip = 1'b0;
    r.val  = 32'(v);
    if (v > hi) begin
      r.val  = 32'(hi);
      r.clip = 1'b1;
    end else if (v < lo) begin
      r.val  = 32'(lo);
      r.clip = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/jt6295_mixn_sat.sv
// Combinational master-gain shift and clamp from the AW-bit frame sum to OW bits plus clip.
module jt6295_mixn_sat
  import jt6295_pkg::*;
#(
  parameter int AW = 15,
  parameter int OW = 14
) (
  input  logic signed [AW-1:0] acc,
  input  logic        [2:0]    gain,
  output logic signed [OW-1:0] sound,
  output logic                 clip
);

  localparam int XW = AW + 7;

  logic signed [XW-1:0] scaled;
  sat_t                 r;
  logic                 unused_hi;

  always_comb begin
    scaled = XW'(acc) <<< gain;
    r      = saturate(64'(scaled), OW);
  end

  assign sound     = r.val[OW-1:0];
  assign clip      = r.clip;
  assign unused_hi = ^r.val[31:OW];

endmodule

// File: rtl/jt6295_mixn.sv
// N-channel ADPCM slot mixer: per-frame accumulate with mute, gain shift, saturation.
// Optional peak-hold meter enabled by defining JT6295_PEAK_EN.
module jt6295_mixn
  import jt6295_pkg::*;
#(
  parameter int CH = 4,
  parameter int IW = 12,
  parameter int OW = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 cen_sl,
  input  logic signed [IW-1:0] snd_in,
  input  logic        [CH-1:0] mute,
  input  logic        [2:0]    gain,
  output logic signed [OW-1:0] sound,
  output logic                 sample,
  output logic                 clip,
  output logic                 ovf,
  input  logic                 ovf_clr,
  output logic        [OW-1:0] peak,
  input  logic                 peak_clr
);

  localparam int SW = slot_w(CH);
  localparam int AW = acc_w(CH, IW);
  localparam int MW = 2 ** SW;

  generate
    if (!cfg_ok(CH, IW, OW)) begin : g_bad_cfg
      $error("jt6295_mixn: illegal CH/IW/OW combination");
    end
  endgenerate

  logic        [SW-1:0] slot;
  logic signed [AW-1:0] acc;
  logic        [MW-1:0] mute_x;
  logic        [SW-1:0] idx;
  logic signed [AW-1:0] contrib;
  logic                 full;
  logic                 ovf_set;
  logic signed [OW-1:0] sat_sound;
  logic                 sat_clip;

  // A slot arriving with cen belongs to the new frame, so it is slot 0.
  assign mute_x  = MW'(mute);
  assign idx     = cen ? '0 : slot;
  assign contrib = mute_x[idx] ? '0 : AW'(snd_in);
  assign full    = (slot == SW'(CH));
  assign ovf_set = cen_sl && !cen && full;

  jt6295_mixn_sat #(.AW(AW), .OW(OW)) u_sat (
    .acc   (acc),
    .gain  (gain),
    .sound (sat_sound),
    .clip  (sat_clip)
  );

  // Frame accumulation stage -> registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot   <= '0;
      acc    <= '0;
      sound  <= '0;
      clip   <= 1'b0;
      sample <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      sample <= cen;
      if (cen) begin
        sound <= sat_sound;
        clip  <= sat_clip;
        acc   <= cen_sl ? contrib : '0;
        slot  <= cen_sl ? SW'(1) : '0;
      end else if (cen_sl && !full) begin
        acc  <= acc + contrib;
        slot <= slot + SW'(1);
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

`ifdef JT6295_PEAK_EN
  localparam logic signed [OW-1:0] SMIN = {1'b1, {(OW-1){1'b0}}};
  localparam logic signed [OW-1:0] SMAX = ~SMIN;

  logic [OW-1:0] mag;

  always_comb begin
    mag = sat_sound;
    if (sat_sound[OW-1]) mag = (sat_sound == SMIN) ? SMAX : -sat_sound;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak <= '0;
    end else if (cen) begin
      if (peak_clr || (mag > peak)) peak <= mag;
    end else if (peak_clr) begin
      peak <= '0;
    end
  end
`else
  logic unused_peak;
  assign peak        = '0;
  assign unused_peak = peak_clr;
`endif

endmodule

// File: tb/tb_jt6295_mixn.sv
// Randomised self-checking bench for jt6295_mixn with a frame-level reference model.
module tb_jt6295_mixn;

  localparam int CH   = 4;
  localparam int IW   = 12;
  localparam int OW   = 14;
  localparam int MAXV = (1 << (OW - 1)) - 1;
  localparam int MINV = -(1 << (OW - 1));

  logic                 clk = 0;
  logic                 rst_n = 0;
  logic                 cen = 0, cen_sl = 0, ovf_clr = 0, peak_clr = 0;
  logic signed [IW-1:0] snd_in = '0;
  logic        [CH-1:0] mute = '0;
  logic        [2:0]    gain = '0;
  logic signed [OW-1:0] sound;
  logic                 sample, clip, ovf;
  logic        [OW-1:0] peak;

  jt6295_mixn #(.CH(CH), .IW(IW), .OW(OW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cen_sl(cen_sl), .snd_in(snd_in),
    .mute(mute), .gain(gain), .sound(sound), .sample(sample), .clip(clip),
    .ovf(ovf), .ovf_clr(ovf_clr), .peak(peak), .peak_clr(peak_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  // reference model state
  int q[$];
  int exp_sound = 0, exp_peak = 0;
  bit exp_clip = 0, exp_sample = 0, exp_ovf = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    exp_sound = 0; exp_peak = 0; exp_clip = 0; exp_sample = 0; exp_ovf = 0;
  endfunction

  function automatic void model_step(input bit c, input bit s, input int v,
                                     input logic [CH-1:0] m, input int g,
                                     input bit oc, input bit pc);
    longint sum, sc;
    int     a;
    bit     oev;
    oev = 0;
    exp_sample = c;
    if (c) begin
      sum = 0;
      foreach (q[i]) sum += q[i];
      sc = sum * (longint'(1) << g);
      exp_clip = 1;
      if (sc > MAXV)      exp_sound = MAXV;
      else if (sc < MINV) exp_sound = MINV;
      else begin
        exp_sound = int'(sc);
        exp_clip  = 0;
      end
      q.delete();
      if (s) q.push_back(m[0] ? 0 : v);
`ifdef JT6295_PEAK_EN
      a = (exp_sound < 0) ? -exp_sound : exp_sound;
      if (a > MAXV) a = MAXV;
      if (pc || a > exp_peak) exp_peak = a;
`endif
    end else begin
      if (s) begin
        if (q.size() == CH) oev = 1;
        else q.push_back(m[q.size()] ? 0 : v);
      end
`ifdef JT6295_PEAK_EN
      if (pc) exp_peak = 0;
`endif
    end
    if (oev) exp_ovf = 1;
    else if (oc) exp_ovf = 0;
    a = 0;
  endfunction

  task automatic tick(input bit c, input bit s, input int v, input logic [CH-1:0] m,
                      input int g, input bit oc, input bit pc);
    cen = c; cen_sl = s; snd_in = IW'(v); mute = m; gain = 3'(g);
    ovf_clr = oc; peak_clr = pc;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(c, s, v, m, g, oc, pc);
    #1;
    cen = 0; cen_sl = 0; ovf_clr = 0; peak_clr = 0;
  endtask

  task automatic run_frame(input int v[$], input logic [CH-1:0] m, input int g, input bit pc);
    foreach (v[i]) tick(0, 1, v[i], m, g, 0, 0);
    tick(1, 0, 0, m, g, 0, pc);
  endtask

  function automatic int rs();
    return int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW - 1));
  endfunction

  function automatic bit rb(input int n);
    return $urandom_range(0, n - 1) == 0;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      check("sound",  sound,  exp_sound);
      check("clip",   clip,   exp_clip);
      check("sample", sample, exp_sample);
      check("ovf",    ovf,    exp_ovf);
      check("peak",   peak,   exp_peak);
    end
  end

  int vals[$];
  int n, g;

  initial begin
    model_reset();
    chk_on = 1;
    repeat (3) tick(0, 0, 0, '0, 0, 0, 0);
    check("rst_sound", sound, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1;
    tick(0, 0, 0, '0, 0, 0, 0);

    vals = {100, -50, 25, 7};
    run_frame(vals, 4'b0000, 0, 0);
    check("basic_sound", sound, 82);
    check("basic_sample", sample, 1);
    check("basic_clip", clip, 0);
    tick(0, 0, 0, '0, 0, 0, 0);
    check("basic_sample_low", sample, 0);

    vals = {2047, 2047, 2047, 2047};
    run_frame(vals, 4'b0000, 2, 0);
    check("clamp_pos", sound, 8191);
    check("clamp_pos_clip", clip, 1);
    vals = {-2048, -2048, -2048, -2048};
    run_frame(vals, 4'b0000, 2, 0);
    check("clamp_neg", sound, -8192);
    check("clamp_neg_clip", clip, 1);

    vals = {10, 20, 30, 40};
    run_frame(vals, 4'b0101, 0, 0);
    check("mute_sound", sound, 60);

    vals = {1, 2, 3, 4, 5, 6};
    run_frame(vals, 4'b0000, 0, 0);
    check("ovf_sound", sound, 10);
    check("ovf_set", ovf, 1);
    tick(0, 0, 0, '0, 0, 0, 0);
    check("ovf_sticky", ovf, 1);
    tick(0, 0, 0, '0, 0, 1, 0);
    check("ovf_clr", ovf, 0);

    vals = {1, 2, 3};
    foreach (vals[i]) tick(0, 1, vals[i], '0, 0, 0, 0);
    tick(1, 1, 5, '0, 0, 0, 0);
    check("coinc_prev", sound, 6);
    vals = {10, 10, 10};
    run_frame(vals, 4'b0000, 0, 0);
    check("coinc_next", sound, 35);

    vals = {-300};
    run_frame(vals, 4'b0000, 0, 0);
    vals = {120};
    run_frame(vals, 4'b0000, 0, 0);
`ifdef JT6295_PEAK_EN
    check("peak_hold", peak, 300);
`else
    check("peak_off", peak, 0);
`endif
    vals = {50};
    run_frame(vals, 4'b0000, 0, 1);
`ifdef JT6295_PEAK_EN
    check("peak_clr", peak, 50);
`else
    check("peak_off2", peak, 0);
`endif

    vals = {1, 1, 1, 1, 1, 1};
    run_frame(vals, 4'b0000, 0, 0);
    tick(0, 1, 9, '0, 0, 0, 0);
    tick(0, 1, 9, '0, 0, 0, 0);
    rst_n = 0;
    model_reset();
    #1;
    check("midrst_sound", sound, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_clip", clip, 0);
    check("midrst_peak", peak, 0);
    tick(0, 0, 0, '0, 0, 0, 0);
    rst_n = 1;
    vals = {1, 1, 1, 1};
    run_frame(vals, 4'b0000, 0, 0);
    check("post_rst_sound", sound, 4);

    for (int f = 0; f < 400; f++) begin
      n = $urandom_range(0, CH + 2);
      g = $urandom_range(0, 7);
      for (int k = 0; k < n; k++) begin
        if (rb(3)) tick(0, 0, 0, CH'($urandom), g, rb(8), 0);
        tick(0, 1, rs(), CH'($urandom), g, rb(8), 0);
      end
      tick(1, rb(4), rs(), CH'($urandom), g, rb(8), rb(4));
    end

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
